// File: rtl/npc_bp_unit_pkg.sv
// Shared encodings for next-PC selection and BTB saturating counters.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package npc_bp_unit_pkg;

    // EX-stage next-PC operation select
    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    // 2-bit saturating counter states; bit 1 is the taken prediction
    localparam logic [1:0] BTB_CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] BTB_CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] BTB_CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] BTB_CTR_STRONG_T  = 2'b11;

    // Saturating step toward the resolved direction
    function automatic logic [1:0] btb_ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == BTB_CTR_STRONG_T) ? ctr : ctr + 2'd1;
        end
        return (ctr == BTB_CTR_STRONG_NT) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer: storage, combinational lookup, counter training.
// Latency: lookup is combinational; updates become visible the cycle after the write edge.
// Backpressure: none; an update is accepted every cycle it is presented.
module npc_btb
    import npc_bp_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    // lookup side: word address of the fetch PC (byte offset dropped)
    input  logic [XLEN-3:0] lk_word,
    output logic            lk_taken,
    output logic [XLEN-1:0] lk_target,
    // training side: word address of the resolved instruction
    input  logic            up_en,
    input  logic [XLEN-3:0] up_word,
    input  logic            up_taken,
    input  logic [XLEN-1:0] up_target
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - 2 - IDX;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]        tag_q [BTB_ENTRIES];
    logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];
    logic [1:0]             ctr_q [BTB_ENTRIES];

    logic [IDX-1:0]  lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;

    logic [IDX-1:0]  up_idx;
    logic [TAGW-1:0] up_tag;
    logic            up_hit;
    logic            up_wr_ctr;
    logic            up_wr_tgt;
    logic [1:0]      up_ctr_d;

    assign lk_idx = lk_word[IDX-1:0];
    assign lk_tag = lk_word[XLEN-3:IDX];
    assign up_idx = up_word[IDX-1:0];
    assign up_tag = up_word[XLEN-3:IDX];

    // Lookup reads pre-update contents, so a same-index write shows up next cycle
    always_comb begin
        lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken  = lk_hit && ctr_q[lk_idx][1];
        lk_target = tgt_q[lk_idx];
    end

    // Training decision: a hit always trains the counter, a miss allocates only when taken
    always_comb begin
        up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_wr_ctr = up_en && (up_hit || up_taken);
        up_wr_tgt = up_en && up_taken;
        up_ctr_d  = up_hit ? btb_ctr_next(ctr_q[up_idx], up_taken) : BTB_CTR_WEAK_T;
    end

    // Valid bits and counters are the only state cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                ctr_q[i] <= BTB_CTR_STRONG_NT;
            end
        end else if (up_wr_ctr) begin
            valid_q[up_idx] <= 1'b1;
            ctr_q[up_idx]   <= up_ctr_d;
        end
    end

    // Tag and target only matter behind a valid bit, so they carry no reset
    always_ff @(posedge clk) begin
        if (!rst && up_wr_tgt) begin
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= up_target;
        end
    end

endmodule

// File: rtl/npc_bp_unit.sv
// Next-PC unit: fetch PC register, BTB prediction, EX resolve and mispredict redirect.
// Latency: prediction and flush are combinational; redirect lands on pc one edge after resolve.
// Backpressure: pc_write=0 holds the PC; a flush overrides the stall, BTB training never stalls.
module npc_bp_unit
    import npc_bp_unit_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [2:0]      ex_npcop,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_aluout,
    input  logic            ex_zero,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            flush
);

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] JALR_MSK = ~XLEN'(1);

    logic [XLEN-1:0] pc_q;
    logic            btb_taken;
    logic [XLEN-1:0] btb_target;

    logic            act_taken;
    logic [XLEN-1:0] act_target;
    logic [XLEN-1:0] correct_npc;
    logic            mispredict;
    logic            btb_up_en;

    npc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .lk_word   (pc_q[XLEN-1:2]),
        .lk_taken  (btb_taken),
        .lk_target (btb_target),
        .up_en     (btb_up_en),
        .up_word   (ex_pc[XLEN-1:2]),
        .up_taken  (act_taken),
        .up_target (act_target)
    );

    // Fetch-side prediction: fall through to pc+4 unless the BTB says taken
    always_comb begin
        pred_taken  = btb_taken;
        pred_target = btb_taken ? btb_target : pc_q + PC_STEP;
    end

    // Resolve the EX instruction and compare against what IF predicted for it
    always_comb begin
        act_taken  = 1'b0;
        act_target = ex_pc + ex_imm;
        case (ex_npcop)
            NPC_BRANCH: act_taken = ex_zero;
            NPC_JUMP:   act_taken = 1'b1;
            NPC_JALR: begin
                act_taken  = 1'b1;
                act_target = ex_aluout & JALR_MSK;
            end
            default:    act_taken = 1'b0;
        endcase
        correct_npc = act_taken ? act_target : ex_pc + PC_STEP;
        // a PLUS4 that aliased into a taken prediction is caught by the direction test
        mispredict  = (ex_pred_taken != act_taken) ||
                      (act_taken && (ex_pred_target != act_target));
        flush       = ex_valid && mispredict && !rst;
        // only control-flow instructions train the BTB
        btb_up_en   = ex_valid && (ex_npcop != NPC_PLUS4);
    end

    // PC register: reset, then redirect, then advance, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (flush) begin
            pc_q <= correct_npc;
        end else if (pc_write) begin
            pc_q <= pred_target;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_npc_bp_unit.sv
module tb_npc_bp_unit;
    import npc_bp_unit_pkg::*;

    localparam int          ENTRIES = 16;
    localparam logic [31:0] RST_PC  = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b0;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [2:0]  ex_npcop = NPC_PLUS4;
    logic [31:0] ex_imm = '0;
    logic [31:0] ex_aluout = '0;
    logic        ex_zero = 1'b0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        flush;

    int total = 0;
    int bad = 0;

    // reference state: architectural PC plus an abstract table of predictor entries
    logic [31:0] m_pc;
    bit          m_v   [ENTRIES];
    logic [31:0] m_tag [ENTRIES];
    logic [31:0] m_tgt [ENTRIES];
    int          m_ctr [ENTRIES];

    npc_bp_unit #(
        .XLEN        (32),
        .BTB_ENTRIES (ENTRIES),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write       (pc_write),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_npcop       (ex_npcop),
        .ex_imm         (ex_imm),
        .ex_aluout      (ex_aluout),
        .ex_zero        (ex_zero),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .flush          (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] a);
        return a / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_v[m_idx(a)] && (m_tag[m_idx(a)] == m_tagof(a));
    endfunction

    function automatic bit m_ptaken(input logic [31:0] a);
        return m_hit(a) && (m_ctr[m_idx(a)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] a);
        return m_ptaken(a) ? m_tgt[m_idx(a)] : a + 32'd4;
    endfunction

    task automatic m_reset();
        m_pc = RST_PC;
        for (int i = 0; i < ENTRIES; i++) begin
            m_v[i]   = 1'b0;
            m_ctr[i] = 0;
        end
    endtask

    // one clock: check outputs against the model, take the edge, advance the model
    task automatic tick();
        bit          at;
        bit          mp;
        bit          e_flush;
        logic [31:0] atgt;
        logic [31:0] cnpc;
        logic [31:0] e_ptgt;
        int          ix;
        #1;
        at = (ex_npcop == NPC_BRANCH && ex_zero) || ex_npcop == NPC_JUMP || ex_npcop == NPC_JALR;
        atgt = (ex_npcop == NPC_JALR) ? {ex_aluout[31:1], 1'b0} : ex_pc + ex_imm;
        cnpc = at ? atgt : ex_pc + 32'd4;
        mp = (ex_pred_taken != at) || (at && ex_pred_target != atgt);
        e_flush = !rst && ex_valid && mp;
        e_ptgt = m_ptgt(m_pc);
        chk("pc", pc, m_pc);
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, m_ptaken(m_pc)});
        chk("pred_target", pred_target, e_ptgt);
        chk("flush", {31'b0, flush}, {31'b0, e_flush});
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            if (ex_valid && ex_npcop != NPC_PLUS4) begin
                ix = m_idx(ex_pc);
                if (m_hit(ex_pc)) begin
                    m_ctr[ix] = at ? ((m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3)
                                   : ((m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0);
                    if (at) m_tgt[ix] = atgt;
                end else if (at) begin
                    m_v[ix]   = 1'b1;
                    m_tag[ix] = m_tagof(ex_pc);
                    m_tgt[ix] = atgt;
                    m_ctr[ix] = 2;
                end
            end
            if (e_flush) m_pc = cnpc;
            else if (pc_write) m_pc = e_ptgt;
        end
        #1;
    endtask

    task automatic set_ex(input logic [31:0] epc, input logic [2:0] op, input logic [31:0] imm,
                          input logic [31:0] alu, input logic z, input logic pt, input logic [31:0] ptg);
        ex_valid       = 1'b1;
        ex_pc          = epc;
        ex_npcop       = op;
        ex_imm         = imm;
        ex_aluout      = alu;
        ex_zero        = z;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
    endtask

    // steer fetch to addr via an aliased PLUS4 mispredict (no BTB write)
    task automatic redirect(input logic [31:0] addr);
        set_ex(addr - 32'd4, NPC_PLUS4, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        tick();
        ex_valid = 1'b0;
    endtask

    logic [31:0] pool [6] = '{32'h10, 32'h50, 32'h90, 32'h20, 32'h24, 32'h1000};
    logic [2:0]  ops  [4] = '{NPC_PLUS4, NPC_BRANCH, NPC_JUMP, NPC_JALR};

    initial begin
        logic [31:0] a;
        // reset held two cycles with a mispredicting EX present: flush must stay low
        rst = 1'b1;
        pc_write = 1'b1;
        set_ex(32'h80, NPC_JUMP, 32'h40, 32'h0, 1'b0, 1'b0, 32'h84);
        @(posedge clk);
        #1;
        m_reset();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_ptaken", {31'b0, pred_taken}, 32'h0);
        chk("rst_ptarget", pred_target, 32'h4);
        chk("rst_flush", {31'b0, flush}, 32'h0);
        rst = 1'b0;
        ex_valid = 1'b0;
        tick(); chk("seq_4", pc, 32'h4);
        tick(); chk("seq_8", pc, 32'h8);
        tick(); chk("seq_c", pc, 32'hC);

        // cold taken branch at 0x10
        set_ex(32'h10, NPC_BRANCH, 32'h20, 32'h0, 1'b1, 1'b0, 32'h14);
        #1 chk("cold_flush", {31'b0, flush}, 32'h1);
        tick();
        chk("cold_pc", pc, 32'h30);
        ex_valid = 1'b0;

        // re-fetch the branch: allocated entry predicts taken
        redirect(32'h10);
        chk("train_pc", pc, 32'h10);
        chk("train_ptaken", {31'b0, pred_taken}, 32'h1);
        chk("train_ptarget", pred_target, 32'h30);
        pc_write = 1'b0;
        set_ex(32'h10, NPC_BRANCH, 32'h20, 32'h0, 1'b1, 1'b1, 32'h30);
        #1 chk("train_noflush", {31'b0, flush}, 32'h0);
        tick();
        chk("train_stall_pc", pc, 32'h10);
        // not taken while predicted taken: redirect to fall-through, ctr 3->2
        set_ex(32'h10, NPC_BRANCH, 32'h20, 32'h0, 1'b0, 1'b1, 32'h30);
        tick();
        chk("nt1_pc", pc, 32'h14);
        ex_valid = 1'b0;
        redirect(32'h10);
        chk("nt1_ptaken", {31'b0, pred_taken}, 32'h1);
        set_ex(32'h10, NPC_BRANCH, 32'h20, 32'h0, 1'b0, 1'b1, 32'h30);
        tick();
        ex_valid = 1'b0;
        redirect(32'h10);
        chk("nt2_ptaken", {31'b0, pred_taken}, 32'h0);
        chk("nt2_ptarget", pred_target, 32'h14);

        // JALR clears bit 0 of the target
        set_ex(32'h40, NPC_JALR, 32'h0, 32'h1235, 1'b0, 1'b0, 32'h44);
        tick();
        chk("jalr_pc", pc, 32'h1234);
        ex_valid = 1'b0;
        redirect(32'h40);
        chk("jalr_ptaken", {31'b0, pred_taken}, 32'h1);
        chk("jalr_ptarget", pred_target, 32'h1234);

        // stall holds the PC, then a mispredict overrides the stall
        pc_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", pc, 32'h40);
        end
        set_ex(32'h200, NPC_JUMP, 32'h100, 32'h0, 1'b0, 1'b0, 32'h204);
        tick();
        chk("stall_flush_pc", pc, 32'h300);
        ex_valid = 1'b0;

        // 0x50 aliases 0x10 at index 4: no hit, then eviction
        redirect(32'h50);
        chk("alias_nohit", {31'b0, pred_taken}, 32'h0);
        set_ex(32'h50, NPC_BRANCH, 32'h10, 32'h0, 1'b1, 1'b0, 32'h54);
        tick();
        chk("alias_pc", pc, 32'h60);
        ex_valid = 1'b0;
        redirect(32'h10);
        chk("evict_old", {31'b0, pred_taken}, 32'h0);
        redirect(32'h50);
        chk("evict_new_ptaken", {31'b0, pred_taken}, 32'h1);
        chk("evict_new_ptarget", pred_target, 32'h60);

        // mid-stream reset wipes the table
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_pc", pc, RST_PC);
        redirect(32'h50);
        chk("midrst_50", {31'b0, pred_taken}, 32'h0);
        redirect(32'h40);
        chk("midrst_40", {31'b0, pred_taken}, 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            pc_write = ($urandom_range(0, 3) != 0);
            a = pool[$urandom_range(0, 5)];
            set_ex(a, ops[$urandom_range(0, 3)], 32'($signed($urandom_range(0, 32)) - 16) * 4,
                   $urandom, 1'($urandom), 1'b0, 32'h0);
            ex_valid = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 9) < 6) begin
                ex_pred_taken  = m_ptaken(a);
                ex_pred_target = m_ptgt(a);
            end else begin
                ex_pred_taken  = 1'($urandom);
                ex_pred_target = $urandom_range(0, 1) ? m_ptgt(a) : pool[$urandom_range(0, 5)];
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npc_bp_unit.md
Name: npc_bp_unit

Overview:
- Parametrised successor to the combinational next-PC logic.
- Owns the architectural PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so IF can predict the next PC.
- Resolves prediction against EX-stage outcome (NPCOp, Zero, IMM, aluout); on mispredict, redirects the PC and flushes the younger stages.

Parameters:
- XLEN, 32, datapath/PC width.
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_write  in  1  1 = PC may advance; 0 = IF stall (hold PC).
- pc  out  XLEN  current fetch PC (registered).
- pred_taken  out  1  IF prediction for pc; piped to EX alongside the instruction.
- pred_target  out  XLEN  predicted next PC for pc (pc+4 when not taken).
- ex_valid  in  1  EX holds a valid, non-flushed instruction.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_npcop  in  3  NPC_PLUS4 / NPC_BRANCH / NPC_JUMP / NPC_JALR.
- ex_imm  in  XLEN  branch/JAL offset.
- ex_aluout  in  XLEN  JALR target (rs1+imm).
- ex_zero  in  1  branch condition true.
- ex_pred_taken  in  1  pred_taken carried with the EX instruction.
- ex_pred_target  in  XLEN  pred_target carried with the EX instruction.
- flush  out  1  combinational; 1 = kill IF/ID instructions this cycle.

Behaviour:
- Index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].
- Entry = {valid, tag, target[XLEN-1:0], ctr[1:0]}.
- Lookup (combinational on pc):
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target : pc+4.
- Resolve (combinational, only when ex_valid):
  - act_taken = (BRANCH && ex_zero) || JUMP || JALR.
  - act_target = JALR ? {ex_aluout[XLEN-1:1],1'b0} : ex_pc+ex_imm; bit 0 is cleared only for JALR.
  - correct_npc = act_taken ? act_target : ex_pc+4.
  - mispredict = ex_pred_taken != act_taken, or (act_taken && ex_pred_target != act_target).
  - flush = ex_valid && mispredict.
  - PLUS4 with ex_pred_taken=1 (aliasing) is a mispredict with correct_npc = ex_pc+4.
- PC update at posedge, priority high→low:
  - rst: pc ← RESET_PC.
  - flush: pc ← correct_npc; overrides stall.
  - pc_write: pc ← pred_target.
  - else: hold.
- BTB update at posedge, when ex_valid and ex_npcop != PLUS4; entry indexed by ex_pc:
  - Hit with matching tag: ctr saturating +1 if act_taken, −1 otherwise (3 max, 0 min). target ← act_target if act_taken.
  - Miss and act_taken: allocate/overwrite; valid=1, tag, target=act_target, ctr=2'b10.
  - Miss and not taken: no write.
  - PLUS4: no BTB write, even on mispredict.
- Update is independent of pc_write; a stall does not block training.
- Same-cycle lookup and update of the same index: lookup returns pre-update contents; the write is visible next cycle.
- Reset, including mid-operation: all valid bits and ctr cleared to 0; flush=0 while rst is high. Outputs after reset: pc=RESET_PC, pred_taken=0, pred_target=RESET_PC+4.
- Arithmetic is modulo 2^XLEN; wrap-around is not trapped.
- Latency: redirect takes effect one cycle after EX resolve; mispredict penalty is fixed by pipeline depth, not by this block.

Decomposition:
- NPC_* opcode defines stay in ctrl_encode_def.v.
- Add BTB_CTR_STRONG_T/WEAK_T/WEAK_NT/STRONG_NT to the same include.
- One sub-module, npc_btb: storage, lookup, counter update. Top holds the PC register, resolve and priority logic.

Test Plan:
- Reset: rst=1 for 2 cycles → pc=0, pred_taken=0, pred_target=4, flush=0; release with pc_write=1 → pc 4, 8, 12 on successive edges.
- Cold taken branch: ex_valid, pc=0x10, BRANCH, zero=1, imm=0x20, pred_taken=0 → flush=1, next pc=0x30, BTB[4] allocated with ctr=2.
- Trained loop: branch at 0x10 re-fetched → pred_taken=1, pred_target=0x30. EX resolves taken → flush=0, ctr=3. Two not-taken resolves → ctr 3→2→1, third fetch predicts 0x14. Not-taken while predicted taken → flush, pc=0x14.
- JALR: pc=0x40, aluout=0x1235, predicted not taken → flush, next pc=0x1234, BTB target=0x1234.
- Stall vs flush: pc_write=0 held, no flush → pc constant for 5 cycles. Mispredict arrives while pc_write=0 → pc still takes correct_npc.
- Aliasing and reset: BTB_ENTRIES=16, branches at 0x10 and 0x50 share index 4 → tag mismatch gives no hit, and the second allocation evicts the first. Assert rst mid-stream → all entries invalid, pc=RESET_PC next edge.
